round_key_fetch: RTL and testbench
==================================

# round_key_fetch

Reads the expanded AES-128 key schedule (rounds 0–10) from the key SRAM that `keyExpansion` fills and streams one 128-bit round key per handshake to the cipher round datapath. It is the read side of the key-schedule SRAM interface. It issues `sramRead`/`sramAddr` itself and buffers keys in a 2-entry FIFO so the consumer can stall. Keys are delivered in forward order (0→10, encrypt) or, when configured, reverse order (10→0, decrypt).

## Interface
- `KEY_BASE_ADDR`, 16'h0000, SRAM address of the round-0 key.
- `ADDR_STRIDE`, 16'd1, address increment between consecutive round keys.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset. **One clock; reset is asynchronous and active-high.**
- `start`  in  1  single-cycle request to begin a full 11-key fetch. Honoured only in IDLE.
- `decrypt`  in  1  sampled with `start`; 1 selects reverse order (see Configuration).
- `sramReadValue`  in  128  SRAM read data. Valid while `sramRead` is high and `sramAddr` is held.
- `sramRead`  out  1  SRAM read strobe.
- `sramAddr`  out  16  SRAM address.
- `roundKey`  out  128  FIFO head data. Passed bit-exact from SRAM, no byte reordering.
- `keyRound`  out  4  round index (0–10) of the FIFO head.
- `keyLast`  out  1  head is the final key of the sequence.
- `keyValid`  out  1  FIFO non-empty.
- `keyReady`  in  1  consumer accepts the head when `keyValid & keyReady` at a rising edge.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse after the last key is popped.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, go to READ.
  - READ: go to CAPTURE.
  - CAPTURE: if keys remain and the FIFO will not be full after this edge, go to READ. If keys remain and the FIFO will be full, go to STALL. If no keys remain, go to FLUSH.
  - STALL: go to READ once the FIFO is not full.
  - FLUSH: when the FIFO is empty, go to IDLE and pulse `done`.
- Round counter is 4 bits.
  - Forward: starts at 0, increments after each capture, last = 10.
  - Reverse: starts at 10, decrements, last = 0.
- `sramAddr` = `KEY_BASE_ADDR + round*ADDR_STRIDE`, truncated to 16 bits (wraps mod 2^16).
- `sramRead` is high only in READ. `sramAddr` is driven in READ and held unchanged through CAPTURE. It is 0 in IDLE.
- `sramReadValue` is sampled at the edge ending CAPTURE. At that edge it is pushed into the FIFO with its round index and last flag.
- FIFO: 2 entries. Push and pop on the same edge are both performed; count is unchanged. A push never occurs when full, which is guaranteed by the STALL gating.
- `start` while busy is ignored; `decrypt` is latched only on accepted `start`.
- `keyRound`/`keyLast`/`roundKey` are registered FIFO head fields, stable while `keyValid & !keyReady`.

## Timing
- Reset values:
  - `sramRead`=0, `sramAddr`=0, `roundKey`=0, `keyRound`=0, `keyLast`=0, `keyValid`=0, `busy`=0, `done`=0.
  - FSM = IDLE, FIFO empty.
- `start` accepted at edge E0:
  - READ during E0–E1.
  - CAPTURE during E1–E2.
  - `keyValid` high after E2, so first-key latency is 2 cycles.
- With `keyReady` held high, one key is delivered every 2 cycles. The last key is valid after E22. `done` pulses in the cycle after the last pop.
- With `keyReady` low throughout, two keys are captured, the FSM sits in STALL, and `sramRead` stays 0 until a pop.
- `rst` asserted mid-fetch immediately clears the FIFO and all outputs and returns to IDLE. No `done` is generated.
- `busy` deasserts in the same cycle `done` pulses.

## Configuration
- `ROUND_KEY_DECRYPT_EN`:
  - Defined: `decrypt`=1 at `start` selects reverse order 10→0, with `keyLast` on round 0.
  - Undefined: the `decrypt` input is ignored, the reverse-order logic is not compiled, and order is always 0→10 with `keyLast` on round 10.

## Test plan
- SRAM preloaded with the FIPS-197 schedule, with `keyReady`=1 and forward `start`:
  - First key = `128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516` with `keyRound`=0.
  - Second key = `128'h2A6C7605_23A33939_88542CB1_A0FAFE17`.
  - Last key = `128'hB6630CA6_E13F0CC8_C9EE2589_D014F9A8` with `keyRound`=10 and `keyLast`=1.
  - `done` pulses once.
- `ROUND_KEY_DECRYPT_EN` defined, `decrypt`=1:
  - First key = round-10 value `B6630CA6…`.
  - Last key = round-0 value `09CF4F3C…` with `keyLast`=1.
- Backpressure, `keyReady`=0 for 20 cycles after `start`:
  - Exactly 2 `sramRead` pulses occur, then FIFO full and no further reads.
  - After release, all 11 keys are delivered in order with none lost or duplicated.
- `start` pulsed again mid-fetch:
  - No effect; the address sequence and key count remain 11.
- `rst` asserted after the 5th key:
  - All outputs 0 at once and FSM in IDLE.
  - A new `start` restarts from round 0 at `KEY_BASE_ADDR`.
- `KEY_BASE_ADDR`=16'hFFFE, `ADDR_STRIDE`=1:
  - Addresses observed are FFFE, FFFF, 0000 … 0008 (wrap).

Source files
------------

// File: rtl/round_key_fetch_if.sv
// round_key_fetch_if: start/config, key SRAM read port and round-key stream of round_key_fetch
interface round_key_fetch_if;
  logic         start;
  logic         decrypt;
  logic [127:0] sramReadValue;
  logic         sramRead;
  logic [15:0]  sramAddr;
  logic [127:0] roundKey;
  logic [3:0]   keyRound;
  logic         keyLast;
  logic         keyValid;
  logic         keyReady;
  logic         busy;
  logic         done;
  modport master (
    input  start, decrypt, sramReadValue, keyReady,
    output sramRead, sramAddr, roundKey, keyRound, keyLast, keyValid, busy, done
  );
  modport slave (
    output start, decrypt, sramReadValue, keyReady,
    input  sramRead, sramAddr, roundKey, keyRound, keyLast, keyValid, busy, done
  );
endinterface

// File: rtl/round_key_fetch.sv
// round_key_fetch: streams the 11 AES-128 round keys from key SRAM through a 2-entry FIFO; reverse order under ROUND_KEY_DECRYPT_EN
module round_key_fetch #(
  parameter logic [15:0] KEY_BASE_ADDR = 16'h0000,
  parameter logic [15:0] ADDR_STRIDE   = 16'd1
) (
  input logic               clk,
  input logic               rst,
  round_key_fetch_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, STALL, FLUSH} state_t;
  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   rnd;
    logic         last;
  } entry_t;

  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d, start_rnd, step_rnd;
  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d, tail_q, tail_d, in_e;
  logic       push, pop, rnd_last;

`ifdef ROUND_KEY_DECRYPT_EN
  logic dec_q, dec_d;
  assign dec_d     = (state_q == IDLE && bus.start) ? bus.decrypt : dec_q;
  assign start_rnd = bus.decrypt ? 4'd10 : 4'd0;
  assign step_rnd  = dec_q ? rnd_q - 4'd1 : rnd_q + 4'd1;
  assign rnd_last  = rnd_q == (dec_q ? 4'd0 : 4'd10);
  // direction is fixed for the whole fetch once start is accepted
  always_ff @(posedge clk or posedge rst)
    if (rst) dec_q <= 1'b0;
    else dec_q <= dec_d;
`else
  assign start_rnd = 4'd0;
  assign step_rnd  = rnd_q + 4'd1;
  assign rnd_last  = rnd_q == 4'd10;
`endif

  assign push    = state_q == CAPTURE;
  assign pop     = count_q != 2'd0 && bus.keyReady;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};
  assign in_e    = '{key: bus.sramReadValue, rnd: rnd_q, last: rnd_last};

  // next state: CAPTURE looks at the post-edge fill level so a push never lands on a full FIFO
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE:    if (bus.start) begin
                 state_d = READ;
                 rnd_d   = start_rnd;
               end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
                 state_d = rnd_last ? FLUSH : (count_d == 2'd2 ? STALL : READ);
                 rnd_d   = step_rnd;
               end
      STALL:   state_d = count_q != 2'd2 ? READ : STALL;
      FLUSH:   state_d = count_q == 2'd0 ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end

  // two-register FIFO: head feeds the outputs directly, tail only holds the second entry
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop) head_d = count_q == 2'd2 ? tail_q : in_e;
    if (push && count_q == 2'd0) head_d = in_e;
    if (push && count_q == 2'd1 && !pop) tail_d = in_e;
  end

  // state, round counter and FIFO registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end

  assign bus.sramRead = state_q == READ;
  assign bus.sramAddr = (state_q == READ || state_q == CAPTURE) ? KEY_BASE_ADDR + {12'd0, rnd_q} * ADDR_STRIDE : 16'd0;
  assign bus.roundKey = head_q.key;
  assign bus.keyRound = head_q.rnd;
  assign bus.keyLast  = head_q.last;
  assign bus.keyValid = count_q != 2'd0;
  assign bus.done     = state_q == FLUSH && count_q == 2'd0;
  assign bus.busy     = state_q != IDLE && !bus.done;
endmodule

// File: tb/tb_round_key_fetch.sv
// tb_round_key_fetch: table-driven fetch runs plus restart, reset and address-wrap sequences, scoreboarded keys
module tb_round_key_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef ROUND_KEY_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam logic [127:0] K0  = 128'h09CF4F3C_ABF71588_28AED2A6_2B7E1516;
  localparam logic [127:0] K1  = 128'h2A6C7605_23A33939_88542CB1_A0FAFE17;
  localparam logic [127:0] K9  = 128'h575C006E_28D12941_19FADC21_AC7766F3;
  localparam logic [127:0] K10 = 128'hB6630CA6_E13F0CC8_C9EE2589_D014F9A8;

  typedef struct { logic [127:0] key; logic [3:0] rnd; logic last; } exp_t;
  typedef struct {
    logic dec; int stall; int exp_win;
    logic [127:0] exp_first; logic [3:0] exp_first_rnd; logic [127:0] exp_second;
    logic [127:0] exp_last; logic [3:0] exp_last_rnd;
  } vec_t;

  round_key_fetch_if b();
  round_key_fetch_if w();
  round_key_fetch u_dut (.clk(clk), .rst(rst), .bus(b));
  round_key_fetch #(.KEY_BASE_ADDR(16'hFFFE), .ADDR_STRIDE(16'd1)) u_wrap (.clk(clk), .rst(rst), .bus(w));

  logic [127:0] mem [11];
  exp_t sb[$];
  exp_t e_m;
  logic [15:0] waddr[$];
  vec_t vt[4];
  int n_cmp = 0, n_fail = 0;
  int rd_idx = 0, pop_cnt = 0, done_cnt = 0, wdone = 0, win, t;
  logic dec_cur = 1'b0, pop_prev = 1'b0;
  logic [127:0] first_key, second_key, last_key;
  logic [3:0] first_rnd, last_rnd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_rnd(input int i);
    return dec_cur ? 4'(10 - i) : 4'(i);
  endfunction

  function automatic logic [127:0] rd_mem(input logic [15:0] i);
    return i < 16'd11 ? mem[int'(i)] : 128'd0;
  endfunction

  always @(posedge clk) if (b.sramRead) b.sramReadValue <= rd_mem(b.sramAddr);
  always @(posedge clk) if (w.sramRead) w.sramReadValue <= rd_mem(w.sramAddr - 16'hFFFE);

  always @(negedge clk) if (!rst) begin
    if (b.sramRead) begin
      chk("sram_addr", 128'(b.sramAddr), 128'(exp_rnd(rd_idx)));
      rd_idx++;
    end
    if (b.keyValid && b.keyReady) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL pop_unexpected: got round %0d expected no key", b.keyRound);
      end else begin
        e_m = sb.pop_front();
        chk("key", b.roundKey, e_m.key);
        chk("key_round", 128'(b.keyRound), 128'(e_m.rnd));
        chk("key_last", 128'(b.keyLast), 128'(e_m.last));
      end
      if (pop_cnt == 0) begin first_key = b.roundKey; first_rnd = b.keyRound; end
      if (pop_cnt == 1) second_key = b.roundKey;
      if (b.keyLast) begin last_key = b.roundKey; last_rnd = b.keyRound; end
      pop_cnt++;
    end
    if (b.done) begin
      done_cnt++;
      chk("done_after_pop", 128'(pop_prev), 128'(1));
      chk("busy_at_done", 128'(b.busy), 128'(0));
    end
    pop_prev = b.keyValid && b.keyReady;
  end

  always @(negedge clk) if (!rst) begin
    if (w.sramRead) waddr.push_back(w.sramAddr);
    if (w.done) wdone++;
  end

  task automatic begin_fetch(input logic dec, input logic rdy);
    exp_t e;
    dec_cur = DEC_EN & dec; rd_idx = 0; pop_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      e.key = mem[exp_rnd(i)]; e.rnd = exp_rnd(i); e.last = i == 10;
      sb.push_back(e);
    end
    b.start = 1'b1; b.decrypt = dec; b.keyReady = rdy;
    @(posedge clk); #1;
    b.start = 1'b0; b.decrypt = 1'b0;
    chk("busy_after_start", 128'(b.busy), 128'(1));
  endtask

  task automatic end_fetch(input string tag);
    int tw = 0;
    while (done_cnt == 0 && tw < 200) begin @(posedge clk); #1; tw++; end
    chk({tag, "_done_seen"}, 128'(done_cnt != 0), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, 128'(done_cnt), 128'(1));
    chk({tag, "_key_count"}, 128'(pop_cnt), 128'(11));
    chk({tag, "_read_count"}, 128'(rd_idx), 128'(11));
    chk({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
    chk({tag, "_busy_idle"}, 128'(b.busy), 128'(0));
    chk({tag, "_addr_idle"}, 128'(b.sramAddr), 128'(0));
    chk({tag, "_valid_idle"}, 128'(b.keyValid), 128'(0));
    sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sramRead"}, 128'(b.sramRead), 128'(0));
    chk({tag, "_sramAddr"}, 128'(b.sramAddr), 128'(0));
    chk({tag, "_roundKey"}, b.roundKey, 128'(0));
    chk({tag, "_keyRound"}, 128'(b.keyRound), 128'(0));
    chk({tag, "_keyLast"}, 128'(b.keyLast), 128'(0));
    chk({tag, "_keyValid"}, 128'(b.keyValid), 128'(0));
    chk({tag, "_busy"}, 128'(b.busy), 128'(0));
    chk({tag, "_done"}, 128'(b.done), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem[0] = K0; mem[1] = K1;
    mem[2] = 128'h7359F67F_5935807A_7A96B943_F2C295F2;
    mem[3] = 128'h6D7A883B_1E237E44_4716FE3E_3D80477D;
    mem[4] = 128'hDB0BAD00_B671253B_A8525B7F_EF44A541;
    mem[5] = 128'h11F915BC_CAF2B8BC_7C839D87_D4D1C6F8;
    mem[6] = 128'hCA0093FD_DBF98641_110B3EFD_6D88A37A;
    mem[7] = 128'h4EA6DC4F_84A64FB2_5F5FC9F3_4E54F70E;
    mem[8] = 128'h7F8D292F_312BF560_B58DBAD2_EAD27321;
    mem[9] = K9; mem[10] = K10;
    vt[0] = '{1'b0, 0, 0, K0, 4'd0, K1, K10, 4'd10};
    vt[1] = '{1'b1, 0, 0, DEC_EN ? K10 : K0, DEC_EN ? 4'd10 : 4'd0, DEC_EN ? K9 : K1, DEC_EN ? K0 : K10, DEC_EN ? 4'd0 : 4'd10};
    vt[2] = '{1'b0, 20, 2, K0, 4'd0, K1, K10, 4'd10};
    vt[3] = '{1'b1, 3, 2, DEC_EN ? K10 : K0, DEC_EN ? 4'd10 : 4'd0, DEC_EN ? K9 : K1, DEC_EN ? K0 : K10, DEC_EN ? 4'd0 : 4'd10};
    b.start = 1'b0; b.decrypt = 1'b0; b.keyReady = 1'b0;
    w.start = 1'b0; w.decrypt = 1'b0; w.keyReady = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      win = 0;
      begin_fetch(vt[v].dec, vt[v].stall == 0);
      for (int k = 0; k < vt[v].stall; k++) begin
        @(negedge clk);
        if (b.sramRead) win++;
        @(posedge clk); #1;
      end
      b.keyReady = 1'b1;
      chk("stall_reads", 128'(win), 128'(vt[v].exp_win));
      end_fetch("vec");
      chk("first_key", first_key, vt[v].exp_first);
      chk("first_round", 128'(first_rnd), 128'(vt[v].exp_first_rnd));
      chk("second_key", second_key, vt[v].exp_second);
      chk("last_key", last_key, vt[v].exp_last);
      chk("last_round", 128'(last_rnd), 128'(vt[v].exp_last_rnd));
    end

    begin_fetch(1'b0, 1'b1);
    @(posedge clk); #1;
    chk("latency_e1_valid", 128'(b.keyValid), 128'(0));
    @(posedge clk); #1;
    chk("latency_e2_valid", 128'(b.keyValid), 128'(1));
    chk("latency_e2_round", 128'(b.keyRound), 128'(0));
    repeat (4) @(posedge clk);
    #1;
    b.start = 1'b1; b.decrypt = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0; b.decrypt = 1'b0;
    chk("restart_busy", 128'(b.busy), 128'(1));
    end_fetch("restart");

    begin_fetch(1'b0, 1'b1);
    t = 0;
    while (pop_cnt < 5 && t < 100) begin @(posedge clk); #1; t++; end
    chk("rst_five_keys", 128'(pop_cnt), 128'(5));
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    @(posedge clk); #1;
    chk("midrst_no_done", 128'(done_cnt), 128'(0));
    sb.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    begin_fetch(1'b0, 1'b1);
    end_fetch("after_rst");
    chk("after_rst_first_key", first_key, K0);
    chk("after_rst_first_round", 128'(first_rnd), 128'(0));

    waddr.delete(); wdone = 0;
    w.start = 1'b1;
    @(posedge clk); #1;
    w.start = 1'b0;
    t = 0;
    while (wdone == 0 && t < 200) begin @(posedge clk); #1; t++; end
    chk("wrap_done", 128'(wdone), 128'(1));
    chk("wrap_reads", 128'(waddr.size()), 128'(11));
    for (int i = 0; i < 11 && i < waddr.size(); i++)
      chk("wrap_addr", 128'(waddr[i]), 128'(16'(32'hFFFE + i)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
